// File: rtl/shifter_pkg.sv
// Types and constants shared by the multi-cycle shift/rotate unit and its
// combinational single-step datapath.
package shifter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SLL,
    SRL,
    SRA,
    ROL,
    ROR
  } mode_t;

  // ROT dominates LA, and LA only matters for right shifts.
  function automatic mode_t mode_decode(input logic rot, input logic lr, input logic la);
    mode_t m;
    if (rot)     m = lr ? ROR : ROL;
    else if (lr) m = la ? SRA : SRL;
    else         m = SLL;
    return m;
  endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// One-bit shift/rotate step: returns the stepped word and the bit moved out.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] y_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] y_o,
  output logic             c_o
);

  always_comb begin
    y_o = y_i;
    c_o = 1'b0;
    case (mode_i)
      SLL: begin
        c_o = y_i[WIDTH-1];
        y_o = {y_i[WIDTH-2:0], 1'b0};
      end
      SRL: begin
        c_o = y_i[0];
        y_o = {1'b0, y_i[WIDTH-1:1]};
      end
      SRA: begin
        c_o = y_i[0];
        y_o = {y_i[WIDTH-1], y_i[WIDTH-1:1]};
      end
      ROL: begin
        c_o = y_i[WIDTH-1];
        y_o = {y_i[WIDTH-2:0], y_i[WIDTH-1]};
      end
      ROR: begin
        c_o = y_i[0];
        y_o = {y_i[0], y_i[WIDTH-1:1]};
      end
      default: begin
        y_o = y_i;
        c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: one single-bit step per clock, with a
// start/busy/done handshake towards the decode FSM.
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] AMT,
  input  logic             LR,
  input  logic             LA,
  input  logic             ROT,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] y_q;
  logic             c_q;
  logic [AMT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] y_d;
  logic             c_d;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .y_i    (y_q),
    .mode_i (mode_q),
    .y_o    (y_d),
    .c_o    (c_d)
  );

  // busy/done are registered alongside the state so they align with it
  // without any decode from state_q on the output side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= SLL;
      y_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            y_q    <= A;
            cnt_q  <= AMT;
            mode_q <= mode_decode(ROT, LR, LA);
            c_q    <= 1'b0;
            busy_q <= 1'b1;
            if (AMT != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          y_q   <= y_d;
          c_q   <= c_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == AMT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign C    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
